// File: rtl/vga_pkg.sv
// Shared timing defaults, counter limits and FSM state encoding for vga_capture.
// Defaults describe standard 640x480 @ 60 Hz timing with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Checksum word for one pixel: {r,g,b} zero-extended to 16 bits.
  function automatic logic [15:0] pix_word(input logic [11:0] rgb);
    return {4'b0000, rgb};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-stage sync register with falling-edge detect; history resets to 1 (idle level)
// so a sync held low through reset release reads as a fresh fall.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic fall
);

  logic stage1;
  logic stage2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= 1'b1;
      stage2 <= 1'b1;
    end else begin
      stage1 <= sync;
      stage2 <= stage1;
    end
  end

  assign fall = !stage1 && stage2;

endmodule

// File: rtl/vga_capture.sv
// VGA timing tracker: locks onto hsync/vsync and emits row/col-tagged pixels 2 clocks after sampling.
// Define VGA_CAPTURE_CHECKSUM_EN to build the per-frame pixel checksum on frame_sum.
//
// state    | meaning
// UNLOCKED | no timing reference, errors ignored
// SEARCH   | one vsync seen, checking one full frame
// LOCKED   | timing verified, pixels forwarded
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [10:0] row,
  output logic [10:0] col,
  output logic        pix_valid,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [15:0] frame_sum
);

  localparam logic [HCNT_W-1:0] H_START = HCNT_W'(H_SYNC + H_BP);
  localparam logic [HCNT_W-1:0] H_END   = HCNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_START = VCNT_W'(V_SYNC + V_BP);
  localparam logic [VCNT_W-1:0] V_END   = VCNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOTAL - 1);

  logic              hfall;
  logic              vfall;
  logic [11:0]       rgb_s1;
  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt_q;
  logic [VCNT_W-1:0] vcnt;
  logic              line_err;
  logic              frame_err;
  logic              lock_next;
  logic              in_active;
  state_t            state;

  sync_edge_detect u_hsync_edge (
    .clk  (clk),
    .rst  (rst),
    .sync (hsync),
    .fall (hfall)
  );

  sync_edge_detect u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .sync (vsync),
    .fall (vfall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_s1 <= '0;
    end else begin
      rgb_s1 <= {red_in, green_in, blue_in};
    end
  end

  // hcnt/vcnt are the positions of the sample currently in stage 1.
  always_comb begin
    hcnt = '0;
    if (!hfall) begin
      hcnt = (hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + 1'b1;
    end
    vcnt = vcnt_q;
    if (vfall) begin
      vcnt = '0;
    end else if (hfall) begin
      vcnt = vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt;
      vcnt_q <= vcnt;
    end
  end

  // The outgoing count is checked against the period length before it restarts.
  assign line_err  = hfall && (hcnt_q != H_LAST);
  assign frame_err = vfall && (vcnt_q != V_LAST);

  // Lock status after this cycle; gating pixels on it drops them the same cycle lock is lost.
  assign lock_next = ((state == LOCKED) && !line_err && !frame_err) ||
                     ((state == SEARCH) && !line_err && vfall && !frame_err);

  assign in_active = lock_next &&
                     (hcnt >= H_START) && (hcnt < H_END) &&
                     (vcnt >= V_START) && (vcnt < V_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      locked      <= 1'b0;
      err         <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      row         <= '0;
      col         <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (vfall) state <= SEARCH;
        end
        SEARCH: begin
          if (line_err) begin
            state <= UNLOCKED;
          end else if (vfall && !frame_err) begin
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (line_err || frame_err) state <= UNLOCKED;
        end
        default: state <= UNLOCKED;
      endcase

      locked      <= lock_next;
      err         <= (state == LOCKED) && (line_err || frame_err);
      frame_start <= vfall && lock_next;
      pix_valid   <= in_active;
      row         <= in_active ? {1'b0, vcnt - V_START} : '0;
      col         <= in_active ? hcnt - H_START : '0;
      {red, green, blue} <= in_active ? rgb_s1 : 12'h000;
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [15:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      frame_sum <= '0;
    end else if (vfall) begin
      frame_sum <= acc;
      acc       <= '0;
    end else if (in_active) begin
      acc <= acc + pix_word(rgb_s1);
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture using a scaled-down timing (28x14 clocks per frame).
// A frame-scenario table plus a cycle-level reference model; honours VGA_CAPTURE_CHECKSUM_EN.
module tb_vga_capture;

  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int H_ACTIVE = 16;
  localparam int H_TOTAL  = 28;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 8;
  localparam int V_TOTAL  = 14;
  localparam int H_START  = H_SYNC + H_BP;
  localparam int H_END    = H_START + H_ACTIVE;
  localparam int V_START  = V_SYNC + V_BP;
  localparam int V_END    = V_START + V_ACTIVE;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  red_in = '0;
  logic [3:0]  green_in = '0;
  logic [3:0]  blue_in = '0;
  logic [10:0] row;
  logic [10:0] col;
  logic        pix_valid;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [15:0] frame_sum;

  always #5 clk = ~clk;

  vga_capture #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .row(row), .col(col), .pix_valid(pix_valid),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .locked(locked), .err(err), .frame_sum(frame_sum)
  );

  typedef struct packed {
    logic        pv;
    logic [10:0] row;
    logic [10:0] col;
    logic [11:0] rgb;
    logic        locked;
    logic        err;
    logic        fs;
    logic [15:0] sum;
  } out_t;

  typedef struct {
    out_t o;
    bit   probe_pix;
    bit   probe_sum;
  } exp_t;

  // One frame scenario: stimulus shape and the pulses/lock it must produce.
  typedef struct {
    int lines;
    int fault_line;
    int fault_len;
    int cmode;
    int fs;
    int errs;
    bit locked_end;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   fs_seen;
  int   err_seen;
  int   last_cmode = 0;

  // Reference model state: positions since last sync falls and lock level 0/1/2.
  bit m_prev_hs, m_prev_vs;
  int m_hpos, m_vpos, m_lvl, m_acc, m_sum;

  function automatic void model_reset();
    m_prev_hs = 1'b1;
    m_prev_vs = 1'b1;
    m_hpos = 0;
    m_vpos = 0;
    m_lvl = 0;
    m_acc = 0;
    m_sum = 0;
  endfunction

  function automatic out_t model(input bit hs, input bit vs, input logic [11:0] c);
    out_t e;
    bit hf, vf, lerr, ferr, was_locked, pv;
    hf = m_prev_hs && !hs;
    vf = m_prev_vs && !vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    lerr = hf && (m_hpos != H_TOTAL - 1);
    ferr = vf && (m_vpos != V_TOTAL - 1);
    m_hpos = hf ? 0 : ((m_hpos < 2047) ? m_hpos + 1 : 2047);
    m_vpos = vf ? 0 : (hf ? (m_vpos + 1) % 1024 : m_vpos);
    was_locked = (m_lvl == 2);
    if (m_lvl == 0) begin
      if (vf) m_lvl = 1;
    end else if (m_lvl == 1) begin
      if (lerr) m_lvl = 0;
      else if (vf && !ferr) m_lvl = 2;
    end else begin
      if (lerr || ferr) m_lvl = 0;
    end
    pv = (m_lvl == 2) && (m_hpos >= H_START) && (m_hpos < H_END) &&
         (m_vpos >= V_START) && (m_vpos < V_END);
    if (vf) begin
      m_sum = m_acc;
      m_acc = 0;
    end else if (pv) begin
      m_acc = (m_acc + int'(c)) % 65536;
    end
    e.pv     = pv;
    e.row    = pv ? 11'(m_vpos - V_START) : 11'd0;
    e.col    = pv ? 11'(m_hpos - H_START) : 11'd0;
    e.rgb    = pv ? c : 12'h000;
    e.locked = (m_lvl == 2);
    e.err    = was_locked && (lerr || ferr);
    e.fs     = vf && (m_lvl == 2);
    e.sum    = CHK ? 16'(m_sum) : 16'd0;
    return e;
  endfunction

  function automatic out_t actual();
    out_t a;
    a.pv = pix_valid;
    a.row = row;
    a.col = col;
    a.rgb = {red, green, blue};
    a.locked = locked;
    a.err = err;
    a.fs = frame_start;
    a.sum = frame_sum;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit hs, input bit vs, input logic [11:0] c, input bit ppix, input bit psum);
    exp_t e;
    out_t cur;
    hsync = hs;
    vsync = vs;
    {red_in, green_in, blue_in} = c;
    e.o = model(hs, vs, c);
    e.probe_pix = ppix;
    e.probe_sum = psum;
    q.push_back(e);
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      cur = actual();
      check("stream", 64'(cur), 64'(e.o));
      if (cur.fs) fs_seen++;
      if (cur.err) err_seen++;
      if (e.probe_pix)
        check("pix_f0a", {40'd0, pix_valid, row, col, red, green, blue},
              {40'd0, 1'b1, 11'd0, 11'd0, 4'hF, 4'h0, 4'hA});
      if (e.probe_sum)
        check("frame_sum", 64'(frame_sum), CHK ? 64'(H_ACTIVE * V_ACTIVE) : 64'd0);
    end
  endtask

  task automatic run_line(input int line, input int start_h, input int len, input int cmode, input bit psum);
    logic [11:0] c;
    bit ppix;
    for (int h = start_h; h < len; h++) begin
      c = (cmode == 1) ? 12'h001 : 12'($urandom);
      ppix = (cmode == 2) && (line == V_START) && (h == H_START);
      if (ppix) c = 12'hF0A;
      step(h >= H_SYNC, line >= V_SYNC, c, ppix, psum && (line == 0) && (h == 0));
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    fs_seen = 0;
    err_seen = 0;
    for (int line = 0; line < v.lines; line++)
      run_line(line, 0, (line == v.fault_line) ? v.fault_len : H_TOTAL, v.cmode, last_cmode == 1);
    last_cmode = v.cmode;
    check($sformatf("f%0d_frame_starts", idx), 64'(fs_seen), 64'(v.fs));
    check($sformatf("f%0d_err_pulses", idx), 64'(err_seen), 64'(v.errs));
    check($sformatf("f%0d_locked_end", idx), 64'(locked), 64'(v.locked_end));
  endtask

  vec_t vecs[16];

  initial begin
    //          lines  fault_line fault_len cmode fs errs locked_end
    vecs[0]  = '{14, -1, 0,    0, 0, 0, 1'b0};
    vecs[1]  = '{14, -1, 0,    0, 1, 0, 1'b1};
    vecs[2]  = '{14, -1, 0,    0, 1, 0, 1'b1};
    vecs[3]  = '{14, 5,  27,   0, 1, 1, 1'b0};
    vecs[4]  = '{14, 5,  27,   0, 0, 0, 1'b0};
    vecs[5]  = '{14, -1, 0,    0, 0, 0, 1'b0};
    vecs[6]  = '{14, -1, 0,    0, 1, 0, 1'b1};
    vecs[7]  = '{13, -1, 0,    0, 1, 0, 1'b1};
    vecs[8]  = '{14, -1, 0,    0, 0, 1, 1'b0};
    vecs[9]  = '{13, -1, 0,    0, 0, 0, 1'b0};
    vecs[10] = '{14, -1, 0,    0, 0, 0, 1'b0};
    vecs[11] = '{14, -1, 0,    1, 1, 0, 1'b1};
    vecs[12] = '{14, -1, 0,    2, 1, 0, 1'b1};
    vecs[13] = '{14, 5,  2100, 0, 1, 1, 1'b0};
    vecs[14] = '{14, -1, 0,    0, 0, 0, 1'b0};
    vecs[15] = '{14, -1, 0,    0, 1, 0, 1'b1};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(actual()), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_frame(i, vecs[i]);

    // Mid-frame reset while pixels are valid, then resume the interrupted frame.
    for (int line = 0; line < 6; line++) run_line(line, 0, H_TOTAL, 0, 1'b0);
    run_line(6, 0, 10, 0, 1'b0);
    check("pre_reset_valid", 64'(pix_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("reset_mid_immediate", 64'(actual()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_mid_hold", 64'(actual()), 64'd0);
    model_reset();
    q.delete();
    rst = 1'b0;
    run_line(6, 10, H_TOTAL, 0, 1'b0);
    for (int line = 7; line < V_TOTAL; line++) run_line(line, 0, H_TOTAL, 0, 1'b0);
    run_frame(100, '{14, -1, 0, 0, 0, 0, 1'b0});
    run_frame(101, '{14, -1, 0, 0, 1, 0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  H_SYNC, 96, hsync pulse width in clocks
  H_BP, 48, horizontal back porch
  H_ACTIVE, 640, visible pixels per line
  H_TOTAL, 800, clocks per line
  V_SYNC, 2, vsync pulse width in lines
  V_BP, 33, vertical back porch
  V_ACTIVE, 480, visible lines
  V_TOTAL, 525, lines per frame
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  pixel clock; single clock domain
  rst  in  1  asynchronous, active-high reset
  hsync  in  1  horizontal sync, active low
  vsync  in  1  vertical sync, active low
  red_in, green_in, blue_in  in  4 each  incoming pixel colour
  row  out  11  active-area line index
  col  out  11  active-area pixel index
  pix_valid  out  1  row/col/colour valid
  red, green, blue  out  4 each  captured pixel colour
  frame_start  out  1  one-cycle pulse at frame start
  locked  out  1  timing lock status
  err  out  1  one-cycle timing-error pulse
  frame_sum  out  16  per-frame pixel checksum

Function
REQ-003 Stage 1 SHALL register all inputs; stage 2 SHALL hold the previous stage-1 sync values. A falling edge is detected when stage 1 is 0 and stage 2 is 1.
REQ-004 hcnt (11 bits) SHALL be 0 on the hsync-fall cycle, increment on all other cycles, and saturate at 2047.
REQ-005 vcnt (10 bits) SHALL be 0 on a vsync fall and increment on each hsync fall. When both falls occur in the same cycle, the vsync fall SHALL take priority.
REQ-006 A line error SHALL be flagged when an hsync fall occurs with hcnt != H_TOTAL-1. A frame error SHALL be flagged when a vsync fall occurs with vcnt != V_TOTAL-1.
REQ-007 The FSM SHALL have three states: UNLOCKED, SEARCH and LOCKED.
  UNLOCKED: on vsync fall, go to SEARCH.
  SEARCH: on a line error, go to UNLOCKED. On a vsync fall with no frame error, go to LOCKED. On a vsync fall with a frame error, stay in SEARCH.
  LOCKED: on a line or frame error, go to UNLOCKED.
REQ-008 err SHALL pulse for one cycle only on an error detected in LOCKED. Errors detected in UNLOCKED SHALL be ignored.
REQ-009 locked SHALL be 1 exactly when the state is LOCKED, registered.
REQ-010 pix_valid SHALL be 1 when all of the following hold: locked, hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-011 When pix_valid is 1, outputs SHALL be col = hcnt-(H_SYNC+H_BP), row = vcnt-(V_SYNC+V_BP), and the colour delayed to align with them. When pix_valid is 0, row, col and colour SHALL be 0.
REQ-012 Latency from input sample to registered output SHALL be exactly 2 clocks.
REQ-013 frame_start SHALL pulse for one cycle, registered, on each vsync fall accepted while in LOCKED or on entry to LOCKED.
REQ-014 On the cycle an error drops lock, pix_valid SHALL deassert with no further valid pixels.

Reset
REQ-015 While rst is high, all outputs and counters SHALL be 0, the pipeline SHALL be cleared with sync history set to 1, and the state SHALL be UNLOCKED.
REQ-016 Reset asserted mid-frame SHALL take effect immediately. After release, relock SHALL require the normal UNLOCKED -> SEARCH -> LOCKED sequence.

Configuration
REQ-017 With VGA_CAPTURE_CHECKSUM_EN defined:
  frame_sum SHALL accumulate, modulo 2^16, {red,green,blue} zero-extended over every pix_valid cycle.
  The total SHALL be latched to frame_sum on each vsync fall, and the accumulator cleared.
REQ-018 Without VGA_CAPTURE_CHECKSUM_EN, frame_sum SHALL be tied to 0 and no accumulator logic SHALL exist.

Structure
REQ-019 Package vga_pkg SHALL hold the default 640x480 timing constants and the FSM state enum (UNLOCKED, SEARCH, LOCKED).
REQ-020 Edge detection SHALL be a sub-module, sync_edge_detect, instantiated once for hsync and once for vsync.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - 3 clean 640x480 frames after reset -> locked=1 one clock after the 2nd vsync fall; frame_start pulses at that point and at every later vsync fall.
  - Locked stream, pixel 0xF0A at hcnt=144, vcnt=35 -> two clocks later row=0, col=0, pix_valid=1, red=F, green=0, blue=A.
  - Locked, one line of 799 clocks -> one-cycle err, then locked=0 and pix_valid=0.
  - Locked, one frame of 524 lines -> err at vsync fall, locked=0, no frame_start.
  - rst pulsed mid-frame -> all outputs 0 immediately; locked returns only after 2 more vsync falls.
  - VGA_CAPTURE_CHECKSUM_EN defined, locked frame of all pixels 0x001 -> frame_sum=0xB000 after the next vsync fall (307200 mod 65536).
